// File: rtl/output_streamer_if.sv
// Memory read port and valid/ready output stream of the output streamer.
// The master side drives the read address and the stream. The slave side is memory plus consumer.
interface output_streamer_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64
);
    localparam int LOGSIZE = $clog2(SIZE);

    logic [LOGSIZE-1:0] rd_addr;
    logic [WIDTH-1:0]   mem_data;
    logic [WIDTH-1:0]   output_data;
    logic               output_valid;
    logic               output_ready;

    modport master (
        output rd_addr,
        output output_data,
        output output_valid,
        input  mem_data,
        input  output_ready
    );

    modport slave (
        input  rd_addr,
        input  output_data,
        input  output_valid,
        output mem_data,
        output output_ready
    );
endinterface

// File: rtl/output_streamer.sv
// Streams words from the output memory onto a valid/ready port, one word per cycle.
// A single registered output stage holds each word, and the memory read is prefetched.
module output_streamer #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LOGSIZE:0]     num_outputs,
    output logic                 busy,
    output logic                 done,
    output_streamer_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [LOGSIZE:0]   SIZE_CNT = (LOGSIZE+1)'(SIZE);
    localparam logic [LOGSIZE:0]   ONE_CNT  = (LOGSIZE+1)'(1);
    localparam logic [LOGSIZE-1:0] ONE_ADDR = LOGSIZE'(1);

    state_t           state, state_next;
    logic [LOGSIZE:0] count;
    logic [LOGSIZE:0] n_lat;
    logic             xfer;
    logic             last;

    function automatic logic [LOGSIZE:0] clamp_count(input logic [LOGSIZE:0] n);
        return (n > SIZE_CNT) ? SIZE_CNT : n;
    endfunction

    assign xfer = bus.output_valid && bus.output_ready;
    assign last = (count == n_lat - ONE_CNT);
    assign done = (state == FINISH);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (num_outputs != '0) ? FILL : FINISH;
            end
            FILL:   state_next = SEND;
            SEND: begin
                if (xfer && last) state_next = FINISH;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output stage: a word is only replaced on a transfer, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_addr      <= '0;
            bus.output_data  <= '0;
            bus.output_valid <= 1'b0;
            count            <= '0;
            n_lat            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && num_outputs != '0) begin
                        n_lat       <= clamp_count(num_outputs);
                        bus.rd_addr <= '0;
                        count       <= '0;
                    end
                end
                FILL: begin
                    bus.output_data  <= bus.mem_data;
                    bus.output_valid <= 1'b1;
                    bus.rd_addr      <= bus.rd_addr + ONE_ADDR;
                end
                SEND: begin
                    if (xfer) begin
                        if (last) begin
                            bus.output_valid <= 1'b0;
                        end else begin
                            bus.output_data <= bus.mem_data;
                            bus.rd_addr     <= bus.rd_addr + ONE_ADDR;
                            count           <= count + ONE_CNT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/output_streamer.md
# output_streamer

Drains results from the output memory and presents them on the block's output stream as a valid/ready handshake, one word per cycle when the consumer is ready. It drives the memory's combinational read port (`rd_addr` → `mem_data`), prefetches one word into a registered output stage, and signals completion so the control FSM can start the next convolution. It is the read-side counterpart to the convolution datapath that writes results into the output memory.

## Interface
- `WIDTH`, 16, data word width (matches output memory).
- `SIZE`, 64, output memory depth in words; power of two.
- `LOGSIZE`, `$clog2(SIZE)`, localparam, address width.

- `clk`, input, 1, single clock; all state updates on the posedge.
- `reset`, input, 1, synchronous, active-high.
- `start`, input, 1, request to stream `num_outputs` words starting at address 0; sampled only in IDLE.
- `num_outputs`, input, LOGSIZE+1, word count; sampled with `start`; values above SIZE clamp to SIZE.
- `rd_addr`, output, LOGSIZE, read address to output memory.
- `mem_data`, input, WIDTH, combinational read data, equal to `mem[rd_addr]` in the same cycle.
- `output_data`, output, WIDTH, registered stream data.
- `output_valid`, output, 1, stream valid.
- `output_ready`, input, 1, consumer ready; a transfer occurs in a cycle where `output_valid && output_ready`.
- `busy`, output, 1, high whenever state is not IDLE.
- `done`, output, 1, single-cycle pulse after the last transfer.

## Operation
- States: IDLE, FILL, SEND, FINISH. Registers: `state`, `rd_addr`, `output_data`, `output_valid`, `count` (LOGSIZE+1 bits, words sent), `n_lat` (latched, clamped count).
- Reset: state=IDLE, `rd_addr`=0, `output_data`=0, `output_valid`=0, `count`=0, `n_lat`=0. Derived outputs follow: `busy`=0, `done`=0.
- IDLE: `start`=1 with `num_outputs`>0 → `n_lat`<=min(`num_outputs`,SIZE), `rd_addr`<=0, `count`<=0, go FILL. With `num_outputs`=0 → go FINISH directly (empty job still produces a `done` pulse). `start`=0 → stay.
- FILL: `output_data`<=`mem_data` (word 0), `output_valid`<=1, `rd_addr`<=`rd_addr`+1, go SEND.
- SEND, transfer with `count`==`n_lat`-1: `output_valid`<=0, go FINISH; `output_data` holds its last value.
- SEND, transfer otherwise: `output_data`<=`mem_data` (next word prefetched at `rd_addr`), `rd_addr`<=`rd_addr`+1, `count`<=`count`+1; `output_valid` stays 1.
- SEND, no transfer: all registers hold. `output_data` and `output_valid` must not change while valid and not ready.
- FINISH: `done`=1 this cycle only, go IDLE.
- `done` = (state==FINISH); `busy` = (state!=IDLE). Both are decoded from state with no extra register.
- `start` outside IDLE is ignored, with no queuing.
- `rd_addr` wraps modulo SIZE. With `n_lat`=SIZE, the final increment wraps to 0; that prefetch value is unused.
- Ordering rule, enforced by the surrounding control: the memory writer must not write during `busy`. The streamer does not check for write collisions.
- `reset` mid-operation: return to reset values on the next edge. Any partially sent stream is abandoned, with no `done` pulse.

## Timing
- `start` sampled at the end of cycle t, then FILL in cycle t+1, then `output_valid`=1 from cycle t+2 (word 0).
- Throughput is 1 word/cycle with `output_ready` held high. The last transfer is in cycle t+1+N, `done` is in cycle t+2+N, and `busy` is 0 and a new `start` is accepted from cycle t+3+N.
- Each stalled cycle (valid=1, ready=0) adds exactly one cycle to the schedule.
- `num_outputs`=0: `done` is in cycle t+1 and `output_valid` never rises.
- `output_ready` is allowed high while valid=0. No transfer occurs and there are no side effects.

## Test plan
- Reset, then preload mem[i]=i+100, `num_outputs`=5, ready held high → words 100..104 in cycles t+2..t+6, `done` in t+7, `busy` low at t+8.
- Same memory, ready toggled 1,0,0,1,0,1… → identical word sequence 100..104. `output_data` stays stable across every stalled cycle, and the stream has no duplicates or drops.
- `num_outputs`=64 (SIZE), ready high → 64 words in order, last word mem[63], `rd_addr` wraps to 0, single `done` pulse.
- `num_outputs`=0 → `done` one cycle after `start`, `output_valid` stays 0. `num_outputs`=100 → exactly 64 words sent (clamped).
- `start` pulsed again mid-stream with `num_outputs`=3 → ignored, and the original 5-word job completes unchanged.
- `reset` asserted after the second transfer → next cycle `output_valid`=0, `busy`=0, `rd_addr`=0, no `done` pulse. A fresh `start` then streams from word 0.
